frame_unloader_n_m: RTL and testbench
=====================================

// Module: frame_unloader_n_m
// PURPOSE
//  Read-side companion to the m-deep write buffer. Snapshots the buffer's parallel m x n word array
//  when the writer flags a full frame, then streams the words out one per transfer under valid/ready.
//  Signals frame completion back to the writer. Sits between the write buffer and the serial consumer.
// PARAMETERS
//  n        32  word width in bits
//  address  4   index counter width; m <= 2**address is required
//  m        16  words per frame
// PORTS
//  clk_i      in   1      single clock, rising edge
//  rst_i      in   1      asynchronous reset, active-low
//  data_i     in   n x m  parallel frame, unpacked [0:m-1]; data_i[0] = oldest word
//  fl_full_i  in   1      writer frame-full flag, level
//  ack_o      out  1      1-cycle pulse: frame captured into internal buffer
//  rd_o       out  n      current output word
//  valid_o    out  1      rd_o holds a valid word
//  ready_i    in   1      consumer accepts rd_o this cycle
//  last_o     out  1      valid_o & current word is index m-1
//  busy_o     out  1      state != IDLE
//  fl_end_o   out  1      1-cycle pulse: last word of frame transferred
//  ovr_o      out  1      sticky: frame request lost (see boundaries)
// BEHAVIOUR
//  Reset (rst_i=0, async): state=IDLE, idx=0, buf[*]=0, pend=0, full_d=0; all outputs 0.
//  Request detect: req = fl_full_i & ~full_d (rising edge); full_d <= fl_full_i every cycle.
//  FSM:
//   IDLE : if (req|pend): buf[k] <= data_i[k] for all k, idx <= 0, pend <= 0, ack_o=1 next cycle -> SEND
//   SEND : valid_o=1, rd_o=buf[idx]. On valid_o&ready_i: if idx==m-1 -> DONE, else idx <= idx+1
//   DONE : fl_end_o=1 for this single cycle, valid_o=0 -> IDLE
//  Latency: request edge at cycle t -> ack_o & first valid_o at t+1; best case frame takes m+2 cycles.
//  Handshake: once valid_o=1, rd_o and last_o stay stable until the transfer; valid_o never drops mid-frame.
//  Order: words leave in index order 0..m-1; the data_i snapshot is taken only in IDLE, never during SEND.
//  idx is address bits wide, compares against m-1, and never wraps past m-1.
//  Boundaries:
//   - req while busy_o=1: pend <= 1; the frame is captured on the first IDLE cycle (after DONE).
//   - req while pend=1 and busy: ovr_o <= 1 (sticky until reset); pend stays 1, no second capture.
//   - req and DONE in the same cycle: pend set, capture on the next IDLE cycle.
//   - ready_i held 0: SEND stalls indefinitely; no timeout.
//   - fl_full_i held high: counts as a single request; it must fall and rise again for the next frame.
//   - reset mid-frame: frame discarded, no fl_end_o pulse, pend cleared.
//   - m=1: SEND lasts one transfer; last_o=1 on that word.
// CONFIGURATION
//  FRAME_PARITY_EN defined:
//   - adds output par_o (1 bit) = ^rd_o, qualified by valid_o (0 when valid_o=0).
//   - adds a per-frame check: if an even-parity word is transferred with last_o=1, ovr_o is not affected.
//   - par_o resets to 0.
//  FRAME_PARITY_EN undefined: par_o port absent; no other behavioural change.
// TESTING (n=32, m=16 unless stated)
//  1. Reset, data_i[k]=32'hA000_0000+k, fl_full_i 0->1, ready_i=1
//     -> ack_o at t+1; rd_o = A0000000..A000000F over 16 consecutive cycles;
//        last_o only on A000000F; fl_end_o pulse on the next cycle.
//  2. Same frame with ready_i toggling 1,0,1,0
//     -> rd_o stable while ready_i=0; 16 words delivered in order, no duplicates or gaps.
//  3. Second fl_full_i edge at word 5 of a frame
//     -> pend=1; new frame captured right after DONE; ovr_o stays 0.
//     A third edge before the capture -> ovr_o=1 and stays 1.
//  4. rst_i=0 pulse at word 8
//     -> valid_o, busy_o and idx go to 0 immediately; no fl_end_o; the next edge restarts at word 0.
//  5. fl_full_i held high across two frame times
//     -> exactly one frame emitted and one fl_end_o pulse.
//  6. FRAME_PARITY_EN, rd_o=32'h0000_0007
//     -> par_o=1; with rd_o=32'h0000_0003 -> par_o=0.
//     Build without the macro compiles with no par_o port.

Source files
------------

// File: rtl/frame_unloader_n_m.sv
// frame_unloader_n_m
//   Read-side companion to an m-deep write buffer. When the writer raises its frame-full flag,
//   the parallel m x n word array is snapshotted into an internal buffer and then streamed out
//   one word per valid/ready transfer, oldest word (index 0) first. Frame completion is signalled
//   back to the writer with a one-cycle fl_end_o pulse.
//
//   Optional feature macro: FRAME_PARITY_EN (adds par_o = ^rd_o, qualified by valid_o).
//
// Ports
//   clk_i      in   clock, rising edge
//   rst_i      in   asynchronous reset, active-low
//   data_i     in   parallel frame [0:m-1], data_i[0] is the oldest word
//   fl_full_i  in   writer frame-full flag (level; rising edge requests a frame)
//   ack_o      out  one-cycle pulse: frame captured
//   rd_o       out  current output word (0 when not valid)
//   valid_o    out  rd_o holds a valid word
//   ready_i    in   consumer accepts rd_o this cycle
//   last_o     out  valid_o and current word is index m-1
//   busy_o     out  unloader not idle
//   fl_end_o   out  one-cycle pulse: last word of the frame transferred
//   ovr_o      out  sticky: a frame request was lost
//   par_o      out  (FRAME_PARITY_EN only) XOR of rd_o while valid_o, else 0

module frame_unloader_n_m #(
  parameter int unsigned n       = 32,
  parameter int unsigned address = 4,
  parameter int unsigned m       = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [n-1:0] data_i [0:m-1],
  input  logic         fl_full_i,
  output logic         ack_o,
  output logic [n-1:0] rd_o,
  output logic         valid_o,
  input  logic         ready_i,
  output logic         last_o,
  output logic         busy_o,
  output logic         fl_end_o,
  output logic         ovr_o
`ifdef FRAME_PARITY_EN
  ,
  output logic         par_o
`endif
);

  localparam logic [address-1:0] LastIdx = address'(m - 1);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e             state_q;
  logic [address-1:0] idx_q;
  logic [n-1:0]       buf_q [0:m-1];
  logic               pend_q;
  logic               full_q;
  logic               ack_q;
  logic               ovr_q;
  logic               req;

  // Only a rising edge of the level flag is a request, so a held flag yields one frame.
  assign req = fl_full_i & ~full_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      full_q  <= 1'b0;
      ack_q   <= 1'b0;
      ovr_q   <= 1'b0;
      for (int k = 0; k < int'(m); k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      full_q <= fl_full_i;
      ack_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // A request remembered while busy is served here without needing a new edge.
          if (req || pend_q) begin
            for (int k = 0; k < int'(m); k++) begin
              buf_q[k] <= data_i[k];
            end
            idx_q   <= '0;
            pend_q  <= 1'b0;
            ack_q   <= 1'b1;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (req) begin
            if (pend_q) ovr_q  <= 1'b1;
            else        pend_q <= 1'b1;
          end
          if (ready_i) begin
            if (idx_q == LastIdx) begin
              state_q <= StDone;
            end else begin
              idx_q <= idx_q + address'(1);
            end
          end
        end
        StDone: begin
          if (req) begin
            if (pend_q) ovr_q  <= 1'b1;
            else        pend_q <= 1'b1;
          end
          idx_q   <= '0;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    valid_o  = (state_q == StSend);
    busy_o   = (state_q != StIdle);
    fl_end_o = (state_q == StDone);
    last_o   = valid_o & (idx_q == LastIdx);
    rd_o     = valid_o ? buf_q[idx_q] : '0;
    ack_o    = ack_q;
    ovr_o    = ovr_q;
  end

`ifdef FRAME_PARITY_EN
  // An even-parity last word has no effect on ovr_o; parity is informational only.
  always_comb begin
    par_o = valid_o & (^rd_o);
  end
`endif

endmodule

// File: tb/tb_frame_unloader_n_m.sv
module tb_frame_unloader_n_m;

  localparam int N = 32;
  localparam int M = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  data_i [0:M-1];
  logic          fl_full_i;
  logic          ack_o;
  logic [N-1:0]  rd_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          busy_o;
  logic          fl_end_o;
  logic          ovr_o;
`ifdef FRAME_PARITY_EN
  logic          par_o;
`endif

  frame_unloader_n_m #(
    .n       (N),
    .address (4),
    .m       (M)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .data_i    (data_i),
    .fl_full_i (fl_full_i),
    .ack_o     (ack_o),
    .rd_o      (rd_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .last_o    (last_o),
    .busy_o    (busy_o),
    .fl_end_o  (fl_end_o),
    .ovr_o     (ovr_o)
`ifdef FRAME_PARITY_EN
    ,
    .par_o     (par_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [N-1:0] w;
    bit           last;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: a frame is "words remaining" plus one trailing done cycle.
  int m_left;
  bit m_done, m_pend, m_ovr, m_ack, m_ff_prev, m_req;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_left = 0; m_done = 0; m_pend = 0; m_ovr = 0; m_ack = 0; m_ff_prev = 0;
      exp_q.delete();
    end else begin
      m_req     = fl_full_i && !m_ff_prev;
      m_ff_prev = fl_full_i;
      m_ack     = 0;
      if (m_left == 0 && !m_done) begin
        if (m_req || m_pend) begin
          for (int k = 0; k < M; k++) exp_q.push_back('{w: data_i[k], last: (k == M - 1)});
          m_left = M;
          m_pend = 0;
          m_ack  = 1;
        end
      end else begin
        if (m_req) begin
          if (m_pend) m_ovr = 1;
          else        m_pend = 1;
        end
        if (m_done) m_done = 0;
        else if (ready_i) begin
          m_left--;
          if (m_left == 0) m_done = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compares outputs with the model away from the active edge.
  always @(negedge clk_i) begin
    check("valid_o", {31'd0, valid_o}, {31'd0, m_left > 0});
    check("busy_o", {31'd0, busy_o}, {31'd0, (m_left > 0) || m_done});
    check("fl_end_o", {31'd0, fl_end_o}, {31'd0, m_done});
    check("ack_o", {31'd0, ack_o}, {31'd0, m_ack});
    check("ovr_o", {31'd0, ovr_o}, {31'd0, m_ovr});
    if (valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", rd_o, 32'hxxxx_xxxx);
      end else begin
        check("rd_o", rd_o, exp_q[0].w);
        check("last_o", {31'd0, last_o}, {31'd0, exp_q[0].last});
`ifdef FRAME_PARITY_EN
        check("par_o", {31'd0, par_o}, {31'd0, ^exp_q[0].w});
`endif
        if (ready_i) void'(exp_q.pop_front());
      end
    end else begin
      check("last_o_idle", {31'd0, last_o}, 32'd0);
`ifdef FRAME_PARITY_EN
      check("par_o_idle", {31'd0, par_o}, 32'd0);
`endif
    end
  end

  bit rand_data;

  task automatic step(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk_i);
      #1;
      if (rand_data) for (int k = 0; k < M; k++) data_i[k] = $urandom;
    end
  endtask

  task automatic do_reset(input int cycles);
    rst_i = 1'b0;
    step(cycles);
    rst_i = 1'b1;
  endtask

  initial begin
    rand_data = 0;
    rst_i     = 1'b0;
    fl_full_i = 1'b0;
    ready_i   = 1'b1;
    for (int k = 0; k < M; k++) data_i[k] = 32'hA000_0000 + k;
    step(3);
    rst_i = 1'b1;
    step(2);

    // Fixed frame, ready high; flag held across several frame times yields one frame.
    fl_full_i = 1'b1;
    step(60);
    fl_full_i = 1'b0;
    step(3);

    // Consumer alternating ready.
    fl_full_i = 1'b1;
    for (int c = 0; c < 50; c++) begin
      ready_i = c[0];
      step(1);
    end
    ready_i   = 1'b1;
    fl_full_i = 1'b0;
    step(3);

    // Second edge mid-frame -> pending; third edge before capture -> overrun.
    rand_data = 1;
    fl_full_i = 1'b1; step(6);
    fl_full_i = 1'b0; step(1);
    fl_full_i = 1'b1; step(3);
    fl_full_i = 1'b0; step(1);
    fl_full_i = 1'b1; step(50);
    fl_full_i = 1'b0; step(2);

    // Reset mid-frame, then restart.
    do_reset(2);
    fl_full_i = 1'b1; step(9);
    do_reset(2);
    fl_full_i = 1'b0; step(2);
    fl_full_i = 1'b1; step(25);
    fl_full_i = 1'b0; step(3);

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 2500; c++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) fl_full_i = ~fl_full_i;
      if ($urandom_range(0, 599) == 0) do_reset(1);
      else step(1);
    end

    // Drain.
    fl_full_i = 1'b0;
    ready_i   = 1'b1;
    step(80);
    check("queue_drained", exp_q.size(), 32'd0);
    check("model_idle", m_left, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
